// File: rtl/mult_seq_32_pkg.sv
// Shared constants, state encoding and gate-level helpers for the sequential
// 32x32 shift-add multiplier.
package mult_seq_32_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int CNT_WIDTH  = 6;

    // Counter value seen on the edge that performs the 32nd (last) step
    localparam logic [CNT_WIDTH-1:0] TERM_CNT = 6'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // 32-bit AND stage
    function automatic logic [31:0] and32(input logic [31:0] x, input logic [31:0] y);
        return x & y;
    endfunction

    // 32-bit inverter followed by increment (two's-complement negation)
    function automatic logic [31:0] neg32(input logic [31:0] x);
        return (~x) + 32'd1;
    endfunction

endpackage

// File: rtl/mult_pp_step_32.sv
// One combinational shift-add step: add the gated multiplicand into the upper
// half of P, keep the carry and shift the whole product right by one.
import mult_seq_32_pkg::*;

module mult_pp_step_32 (
    input  logic [DATA_WIDTH-1:0]   mcnd,
    input  logic [2*DATA_WIDTH-1:0] p,
    output logic [2*DATA_WIDTH-1:0] p_next
);

    logic [DATA_WIDTH-1:0] pp_s;
    logic [DATA_WIDTH:0]   sum_s;

    // Partial product, 33-bit accumulate and right shift
    always_comb begin
        pp_s   = and32(mcnd, {DATA_WIDTH{p[0]}});
        sum_s  = {1'b0, p[2*DATA_WIDTH-1:DATA_WIDTH]} + {1'b0, pp_s};
        p_next = {sum_s, p[DATA_WIDTH-1:1]};
    end

endmodule

// File: rtl/mult_seq_32.sv
// Sequential 32x32->64 shift-add multiplier, one step per clock, 33-cycle latency.
// Define MULT_SIGNED_EN for two's-complement operands (sign-magnitude internally).
import mult_seq_32_pkg::*;

module mult_seq_32 (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [DATA_WIDTH-1:0] HI,
    output logic [DATA_WIDTH-1:0] LO
);

    state_t                  state_r;
    logic [CNT_WIDTH-1:0]    cnt_r;
    logic [2*DATA_WIDTH-1:0] p_r;
    logic [DATA_WIDTH-1:0]   mcnd_r;
    logic [DATA_WIDTH-1:0]   hi_r;
    logic [DATA_WIDTH-1:0]   lo_r;
    logic                    busy_r;
    logic                    done_r;

    logic [DATA_WIDTH-1:0]   mag_a_s;
    logic [DATA_WIDTH-1:0]   mag_b_s;
    logic [2*DATA_WIDTH-1:0] p_next_s;
    logic [2*DATA_WIDTH-1:0] result_s;

`ifdef MULT_SIGNED_EN
    logic sign_r;

    // Operands enter the datapath as magnitudes; the product sign is restored at FIN entry
    always_comb begin
        if (A[DATA_WIDTH-1]) begin
            mag_a_s = neg32(A);
        end else begin
            mag_a_s = A;
        end
        if (B[DATA_WIDTH-1]) begin
            mag_b_s = neg32(B);
        end else begin
            mag_b_s = B;
        end
        if (sign_r) begin
            result_s = (~p_next_s) + 64'd1;
        end else begin
            result_s = p_next_s;
        end
    end

    // Sign of the product captured on an accepted START
    always_ff @(posedge CLK) begin
        if (RST) begin
            sign_r <= 1'b0;
        end else if (START && (state_r != RUN)) begin
            sign_r <= A[DATA_WIDTH-1] ^ B[DATA_WIDTH-1];
        end
    end
`else
    // Unsigned operation: operands and product pass straight through
    always_comb begin
        mag_a_s  = A;
        mag_b_s  = B;
        result_s = p_next_s;
    end
`endif

    mult_pp_step_32 u_step (
        .mcnd   (mcnd_r),
        .p      (p_r),
        .p_next (p_next_s)
    );

    // Control FSM, iteration counter, product register and result registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
            cnt_r   <= 6'd0;
            p_r     <= 64'd0;
            mcnd_r  <= 32'd0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE, FIN: begin
                    done_r <= 1'b0;
                    if (START) begin
                        state_r <= RUN;
                        busy_r  <= 1'b1;
                        mcnd_r  <= mag_a_s;
                        p_r     <= {32'd0, mag_b_s};
                        cnt_r   <= 6'd0;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                RUN: begin
                    p_r   <= p_next_s;
                    cnt_r <= cnt_r + 6'd1;
                    if (cnt_r == TERM_CNT) begin
                        state_r <= FIN;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        hi_r    <= result_s[2*DATA_WIDTH-1:DATA_WIDTH];
                        lo_r    <= result_s[DATA_WIDTH-1:0];
                    end else begin
                        state_r <= RUN;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY = busy_r;
    assign DONE = done_r;
    assign HI   = hi_r;
    assign LO   = lo_r;

endmodule

// File: tb/tb_mult_seq_32.sv
// Self-checking bench for mult_seq_32: cycle-level reference model plus
// directed vectors with hand-computed products.
`timescale 1ns/1ps

module tb_mult_seq_32;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic [31:0] A;
    logic [31:0] B;
    logic        BUSY;
    logic        DONE;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    mult_seq_32 dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .A     (A),
        .B     (B),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] sp;
`ifdef MULT_SIGNED_EN
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        sp = sa * sb;
        return sp;
`else
        sa = 64'd0;
        sb = 64'd0;
        sp = 64'd0;
        return {32'd0, a} * {32'd0, b};
`endif
    endfunction

    // Reference model: busy cycles remaining, pending product, published result
    int          m_rem  = 0;
    bit          m_done = 1'b0;
    logic [63:0] m_pend = 64'd0;
    logic [63:0] m_res  = 64'd0;

    always @(posedge CLK) begin
        if (RST) begin
            m_rem  = 0;
            m_done = 1'b0;
            m_res  = 64'd0;
        end else if (m_rem == 0) begin
            m_done = 1'b0;
            if (START) begin
                m_rem  = 32;
                m_pend = prod(A, B);
            end
        end else begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
                m_done = 1'b1;
                m_res  = m_pend;
            end
        end
    end

    // Compare process: every cycle, away from the active edge
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("busy", {63'd0, BUSY}, {63'd0, (m_rem > 0)});
            chk("done", {63'd0, DONE}, {63'd0, m_done});
            chk("hilo", {HI, LO}, m_res);
        end
    end

    // Wait (bounded) for DONE after START was driven in the current cycle; returns latency
    task automatic wait_done(output int lat);
        lat = 41;
        for (int k = 1; k <= 40; k++) begin
            @(negedge CLK);
            START = 1'b0;
            if (DONE) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp);
        int lat;
        START = 1'b1;
        A     = a;
        B     = b;
        @(negedge CLK);
        START = 1'b0;
        A     = $urandom;
        B     = $urandom;
        wait_done(lat);
        lat = lat + 1;
        chk({name, "_lat"}, 64'(lat), 64'd33);
        chk({name, "_res"}, {HI, LO}, exp);
        chk({name, "_model"}, m_res, exp);
    endtask

    initial begin
        int          lat;
        logic [63:0] held;
        bit          saw_done;
        RST   = 1'b1;
        START = 1'b0;
        A     = 32'd0;
        B     = 32'd0;
        @(negedge CLK);
        chk_en = 1'b1;
        @(negedge CLK);
        chk("reset_out", {BUSY, DONE, HI, LO}, {2'b00, 64'd0});
        RST = 1'b0;
        @(negedge CLK);

        run_op("mul_3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F);
        run_op("mul_0xff", 32'd0, 32'hFFFF_FFFF, 64'd0);
`ifdef MULT_SIGNED_EN
        run_op("s_m3x5", 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op("s_min_min", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        run_op("s_m1_m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
`else
        run_op("u_ff_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
`endif

        // START during RUN is ignored
        START = 1'b1;
        A     = 32'd3;
        B     = 32'd5;
        @(negedge CLK);
        START = 1'b0;
        for (int c = 2; c <= 10; c++) begin
            @(negedge CLK);
            START = (c >= 5 && c <= 10) ? 1'b1 : 1'b0;
            A     = 32'd7;
            B     = 32'd7;
        end
        wait_done(lat);
        chk("ignore_lat", 64'(lat + 10), 64'd33);
        chk("ignore_res", {HI, LO}, 64'h0000_0000_0000_000F);

        // Back-to-back: START in the DONE cycle
        START = 1'b1;
        A     = 32'd2;
        B     = 32'd9;
        @(negedge CLK);
        START = 1'b0;
        chk("b2b_busy", {63'd0, BUSY}, 64'd1);
        wait_done(lat);
        chk("b2b_lat", 64'(lat + 1), 64'd33);
        chk("b2b_res", {HI, LO}, 64'h0000_0000_0000_0012);

        // Result holds through IDLE and the next RUN
        held = {HI, LO};
        repeat (20) @(negedge CLK);
        chk("hold_idle", {HI, LO}, 64'h0000_0000_0000_0012);
        START = 1'b1;
        A     = 32'h0001_0000;
        B     = 32'h0001_0000;
        @(negedge CLK);
        START = 1'b0;
        repeat (15) @(negedge CLK);
        chk("hold_run", {HI, LO}, held);
        wait_done(lat);
        chk("hold_lat", 64'(lat + 16), 64'd33);
        chk("hold_new", {HI, LO}, 64'h0000_0001_0000_0000);

        // Reset mid-operation: cycle 10 of a run
        START = 1'b1;
        A     = 32'd3;
        B     = 32'd5;
        @(negedge CLK);
        START = 1'b0;
        repeat (9) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("abort_out", {BUSY, DONE, HI, LO}, {2'b00, 64'd0});
        saw_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (DONE) saw_done = 1'b1;
        end
        chk("abort_no_done", {63'd0, saw_done}, 64'd0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_seq_32.md
Name: mult_seq_32

Overview:
- Sequential 32x32 -> 64-bit shift-add multiplier for the ALU's multiply path, one partial-product step per clock.
- Sits downstream of the 32-bit logic gate library. Each partial product is formed with the 32-bit AND stage: multiplicand ANDed with the current multiplier bit replicated 32 times.
- The result goes out on HI/LO and is consumed by the register write-back / HI-LO register stage.

Parameters:
- DATA_WIDTH, 32, operand width. Fixed at 32 because the gate library is 32-bit only.
- CNT_WIDTH, 6, iteration counter width. Must hold the value DATA_WIDTH.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous, active-high reset.
- START  input  1  request pulse; sampled only when the block can accept.
- A  input  32  multiplicand, sampled on an accepted START.
- B  input  32  multiplier, sampled on an accepted START.
- BUSY  output  1  high while iterating.
- DONE  output  1  one-cycle pulse when HI/LO carry a new result.
- HI  output  32  product bits 63:32.
- LO  output  32  product bits 31:0.

Behaviour:
- Reset (RST=1 at a CLK edge): state=IDLE, BUSY=0, DONE=0, HI=0, LO=0, counter=0, internal product register P=0. Reset overrides everything, including mid-operation; no DONE is produced for an aborted operation.
- States:
  - IDLE: START=1 -> RUN. Latch MCND=A, P={32'b0,B}, counter=0.
  - RUN: each cycle:
    - pp = MCND AND {32{P[0]}};
    - {c,s} = P[63:32] + pp (33-bit add);
    - P = {c, s, P[31:1]}; counter++.
    - When counter reaches 31 on this edge (32nd step done): -> FIN, and HI/LO are captured from the final P.
  - FIN: DONE=1 for exactly one cycle.
    - START=1 -> RUN with new operands, back-to-back.
    - Otherwise -> IDLE.
- BUSY=1 exactly while state==RUN. DONE=1 exactly while state==FIN.
- Latency: START sampled at edge t -> BUSY high cycles t+1..t+32 -> DONE high in cycle t+33, with HI/LO valid in that same cycle.
- HI/LO are registered and change only on the FIN-entry edge (or reset). They hold the last result through IDLE and the next RUN.
- START while in RUN is ignored and not queued. A/B are don't-care except on the accepting edge.
- Arithmetic: unsigned by default. The carry c is kept, so the full 64-bit product is exact; no overflow flag.
- Multiplier=0 or multiplicand=0 still takes the full 32 cycles (no early termination).

Optional Feature:
- Macro MULT_SIGNED_EN.
- Defined (two's-complement signed operation):
  - On accept, MCND=|A| and P low half=|B|. Negation uses the 32-bit inverter plus increment.
  - A sign flag = A[31]^B[31] is stored.
  - On FIN entry, if the flag is set, {HI,LO} = 64-bit two's-complement negation of P. Otherwise {HI,LO}=P.
  - |−2^31| = 0x80000000, treated as unsigned magnitude, so the result is exact.
  - Latency unchanged.
- Undefined: purely unsigned; no sign flag or negation logic is instantiated.

Decomposition:
- Shared package:
  - state encoding constants IDLE=2'd0, RUN=2'd1, FIN=2'd2;
  - DATA_WIDTH and CNT_WIDTH defaults;
  - the iteration terminal count constant (31).
- One natural sub-module: mult_pp_step_32, the combinational single step.
  - Inputs: MCND, P. Output: next P.
  - Built from the 32-bit AND stage plus a 33-bit adder.
- The top holds the FSM, counter, P, MCND, HI/LO registers and the optional sign logic.

Test Plan:
- Basic multiply: A=3, B=5, START pulse at cycle 0 -> BUSY high cycles 1-32; DONE only in cycle 33; HI=0x00000000, LO=0x0000000F.
- Unsigned extreme: A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; A=0, B=0xFFFFFFFF -> HI=LO=0 after the full 33 cycles.
- Protocol:
  - START re-asserted in cycles 5-10 with A=7, B=7 during a 3*5 run -> ignored; result is still 0x0F.
  - START in the DONE cycle with A=2, B=9 -> BUSY next cycle; second DONE 33 cycles later; LO=0x12.
- Reset mid-operation: RST=1 in cycle 10 of a run -> next cycle BUSY=0, DONE=0, HI=LO=0; no DONE ever appears for that operation.
- MULT_SIGNED_EN defined:
  - A=0xFFFFFFFD (−3), B=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
  - A=0x80000000, B=0x80000000 -> HI=0x40000000, LO=0.
  - A=−1, B=−1 -> HI=0, LO=1.
- Result hold: after DONE, idle 20 cycles -> HI/LO stable. New START -> HI/LO unchanged during RUN, then update only at the next DONE.
